zuma_config_sink: RTL
=====================

# zuma_config_sink

Overlay-side receiver for the ZUMA configuration write stream. Samples `config_en`/`config_addr`/`config_data` from the configuration driver, decodes each address into a one-hot stage write enable plus a LUT row address, and counts accepted words in `progress`. It checks the stream for ordering and completeness, and flags `cfg_done` once a full, in-order image has been loaded. It sits between the configuration port of `ZUMA_custom_generated` and the per-stage configuration LUTRAM chains.

## Interface
- `LUT_SIZE`, 6, LUT input count; each stage holds 2^LUT_SIZE rows
- `NUM_STAGES`, 8, number of configuration stages (≥1)
- `CONFIG_WIDTH`, 32, configuration word width
- `clk` input 1: single clock, all logic on posedge
- `reset` input 1: asynchronous, active-low reset
- `config_en` input 1: write strobe from the driver, one word per cycle while high
- `config_addr` input 32: word address
- `config_data` input CONFIG_WIDTH: configuration word, already bit-order corrected
- `wr_data` output CONFIG_WIDTH: registered copy of the accepted word
- `wr_lut_addr` output LUT_SIZE: row within the stage, `config_addr[LUT_SIZE-1:0]`
- `wr_stage_en` output NUM_STAGES: one-hot stage write enable, `config_addr >> LUT_SIZE`
- `progress` output 32: number of in-range words accepted in the current load
- `cfg_done` output 1: level; full image loaded in order
- `cfg_error` output 1: sticky; ordering or completeness violation in the current load

## Operation
- `DEPTH` = 2^LUT_SIZE * NUM_STAGES, evaluated at 32 bits.
- States: IDLE, LOAD, DONE.
- **IDLE:** `config_en`=1 → LOAD. The same cycle is processed as a LOAD cycle. Entry clears `progress`, `cfg_done` and `cfg_error`.
- **DONE:** `config_en`=1 → LOAD, with the same clearing as from IDLE. This is a reconfiguration.
- **LOAD, `config_en`=1, `config_addr` < DEPTH (in-range write):**
  - Registers `wr_data`, `wr_lut_addr` and the one-hot `wr_stage_en`.
  - `progress` increments.
  - If `config_addr` != `progress` (the pre-increment value), `cfg_error` sets. The write is still performed.
- **LOAD, `config_en`=1, `config_addr` ≥ DEPTH:** Ignored. `wr_stage_en`=0, no count, no error. The driver overshoots past DEPTH and can present a stale first address.
- **LOAD, `config_en`=0:**
  - If `progress` == DEPTH and `cfg_error`=0 → DONE, `cfg_done`=1.
  - Otherwise → IDLE, `cfg_error`=1.
- `wr_stage_en` is all-zero on every cycle that is not an accepted in-range write.
- `progress` saturates at DEPTH. A write arriving when `progress` == DEPTH is an order violation and sets `cfg_error`.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE; `wr_data`, `wr_lut_addr`, `wr_stage_en`, `progress`, `cfg_done` and `cfg_error` are all 0 immediately, independent of `clk`. Deassertion is synchronised by the integrator.
- Latency: 1 cycle. The input sampled at edge N appears on `wr_*` after edge N. `progress` updates at the same edge.
- `cfg_error` is visible 1 cycle after the offending input sample.
- `cfg_done` rises 1 cycle after the first edge that samples `config_en`=0 with a complete image.
- On a new load, `cfg_done`/`cfg_error` fall 1 cycle after the first `config_en`=1 sample.
- No backpressure: every `config_en` cycle is consumed.
- Reset mid-LOAD aborts the load. The following load must restart at address 0.

## Test plan
- **Full load** (LUT_SIZE=2, NUM_STAGES=3, DEPTH=12): addresses 0..11, data=addr, then en=0.
  - `wr_stage_en`=001 for addresses 0–3, 010 for 4–7, 100 for 8–11; `wr_lut_addr`=addr[1:0]; `wr_data`=addr.
  - `progress`=12; `cfg_done`=1 one cycle after en falls; `cfg_error`=0.
- **Overshoot:** same stream followed by addresses 12 and 13 with en=1.
  - `wr_stage_en`=000 on both; `progress` stays 12; `cfg_done`=1, `cfg_error`=0 after en falls.
- **Skip:** addresses 0, 1, 3.
  - `cfg_error`=1 the cycle after address 3 is sampled; stage0 row3 is still written; `progress`=3.
- **Early stop:** en falls after 5 words.
  - `cfg_error`=1, `cfg_done`=0, state IDLE; `wr_stage_en`=0.
- **Async reset mid-load:** assert `reset`=0 after 6 words, between clock edges.
  - All outputs 0 at once.
  - A following clean 0..11 load ends with `cfg_done`=1, `cfg_error`=0.
- **Reconfiguration:** after DONE, restart at address 0.
  - `cfg_done`→0 and `progress`→1 after the first edge.
  - Completing the load sets `cfg_done`=1 again.

Source files
------------

// File: rtl/zuma_config_sink_if.sv
// Configuration write stream between the ZUMA config driver and the overlay sink.
// The driver owns the config_* strobe/address/data. The sink returns the decoded
// write port and the load status.
interface zuma_config_sink_if #(
  parameter int LUT_SIZE     = 6,
  parameter int NUM_STAGES   = 8,
  parameter int CONFIG_WIDTH = 32
);
  logic                    config_en;
  logic [31:0]             config_addr;
  logic [CONFIG_WIDTH-1:0] config_data;

  logic [CONFIG_WIDTH-1:0] wr_data;
  logic [LUT_SIZE-1:0]     wr_lut_addr;
  logic [NUM_STAGES-1:0]   wr_stage_en;
  logic [31:0]             progress;
  logic                    cfg_done;
  logic                    cfg_error;

  modport master (
    output config_en, config_addr, config_data,
    input  wr_data, wr_lut_addr, wr_stage_en, progress, cfg_done, cfg_error
  );

  modport slave (
    input  config_en, config_addr, config_data,
    output wr_data, wr_lut_addr, wr_stage_en, progress, cfg_done, cfg_error
  );
endinterface

// File: rtl/zuma_config_sink.sv
// ZUMA configuration sink: decodes the config write stream into per-stage LUTRAM
// write enables, counts accepted words and validates order and completeness.

// Per-stage address match: this stage owns rows [IDX*2^LUT_SIZE, (IDX+1)*2^LUT_SIZE).
module zuma_stage_dec #(
  parameter int LUT_SIZE = 6,
  parameter int IDX      = 0
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = ((addr >> LUT_SIZE) == 32'(IDX));
endmodule

module zuma_config_sink #(
  parameter int LUT_SIZE     = 6,
  parameter int NUM_STAGES   = 8,
  parameter int CONFIG_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  zuma_config_sink_if.slave  cfg
);
  localparam logic [31:0] DEPTH = 32'(NUM_STAGES) << LUT_SIZE;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state, state_n;
  logic [31:0]             progress_q, progress_n;
  logic                    done_q, done_n;
  logic                    err_q, err_n;
  logic [NUM_STAGES-1:0]   stage_en_q, stage_en_n;
  logic [NUM_STAGES-1:0]   stage_hit;
  logic [CONFIG_WIDTH-1:0] data_q;
  logic [LUT_SIZE-1:0]     lut_q;
  logic                    in_range;
  logic                    accept;
  logic [31:0]             base_prog;
  logic                    base_err;

  // Stage decoders, one per configuration chain.
  genvar s;
  generate
    for (s = 0; s < NUM_STAGES; s++) begin : g_stage
      zuma_stage_dec #(.LUT_SIZE(LUT_SIZE), .IDX(s)) u_dec (
        .addr (cfg.config_addr),
        .hit  (stage_hit[s])
      );
    end
  endgenerate

  // The driver overshoots past the image, so out-of-range words are dropped silently.
  assign in_range = (cfg.config_addr < DEPTH);

  // A load starting from IDLE/DONE processes its first word against a cleared
  // count and error, so the entry cycle behaves exactly like a LOAD cycle.
  assign base_prog = (state == LOAD) ? progress_q : 32'd0;
  assign base_err  = (state == LOAD) ? err_q      : 1'b0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, count, status and stage enable.
  always_comb begin
    state_n    = state;
    progress_n = progress_q;
    done_n     = done_q;
    err_n      = err_q;
    stage_en_n = '0;
    accept     = 1'b0;
    if (cfg.config_en) begin
      state_n    = LOAD;
      done_n     = 1'b0;
      progress_n = base_prog;
      err_n      = base_err;
      if (in_range) begin
        accept     = 1'b1;
        stage_en_n = stage_hit;
        // Saturate at DEPTH; a write there can never match the count, so it
        // is flagged by the order check below.
        if (base_prog != DEPTH) progress_n = base_prog + 32'd1;
        if (cfg.config_addr != base_prog) err_n = 1'b1;
      end
    end else if (state == LOAD) begin
      if (progress_q == DEPTH && !err_q) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        state_n = IDLE;
        err_n   = 1'b1;
      end
    end
  end

  // Status and write-enable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      progress_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stage_en_q <= '0;
    end else begin
      progress_q <= progress_n;
      done_q     <= done_n;
      err_q      <= err_n;
      stage_en_q <= stage_en_n;
    end
  end

  // Write data and row only change on accepted words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      lut_q  <= '0;
    end else if (accept) begin
      data_q <= cfg.config_data;
      lut_q  <= cfg.config_addr[LUT_SIZE-1:0];
    end
  end

  assign cfg.wr_data     = data_q;
  assign cfg.wr_lut_addr = lut_q;
  assign cfg.wr_stage_en = stage_en_q;
  assign cfg.progress    = progress_q;
  assign cfg.cfg_done    = done_q;
  assign cfg.cfg_error   = err_q;
endmodule
